// File: rtl/pt_write_packer.sv
// Packs projective-transform pixel writes into 36-bit ZBT words (two horizontally
// adjacent 18-bit pixels per word) and queues them for the frame-buffer arbiter.
module pt_write_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_WORDS    = 320,
    parameter int IDLE_FLUSH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] pt_pixel_write,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    input  logic        pt_wr,
    output logic        ptflag,
    input  logic        frame_flag,
    output logic [18:0] wr_addr,
    output logic [35:0] wr_data,
    output logic [1:0]  wr_mask,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [3:0]  fifo_count,
    output logic        oob_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_FLUSH + 1);
    localparam logic [3:0]    DEPTH_C     = 4'(FIFO_DEPTH);
    localparam logic [3:0]    HIWAT_C     = 4'(FIFO_DEPTH - 2);
    localparam logic [IW-1:0] IDLE_LAST_C = IW'(IDLE_FLUSH - 1);

    typedef struct packed {
        logic [18:0] addr;
        logic [35:0] data;
        logic [1:0]  mask;
    } word_t;

    function automatic word_t lone_word(input logic [18:0] addr, input logic half,
                                        input logic [17:0] pix);
        word_t w;
        w.addr = addr;
        w.data = half ? {pix, 18'd0} : {18'd0, pix};
        w.mask = half ? 2'b10 : 2'b01;
        return w;
    endfunction

    logic          pend_vld_q,  pend_vld_d;
    logic [18:0]   pend_addr_q, pend_addr_d;
    logic          pend_half_q, pend_half_d;
    logic [17:0]   pend_data_q, pend_data_d;
    logic [IW-1:0] idle_q,      idle_d;
    logic          flush_req_q, flush_req_d;
    logic          oob_q,       oob_d;
    logic          ptflag_q,    ptflag_d;
    logic [PW-1:0] rd_q,        rd_d;
    logic [PW-1:0] wr_q,        wr_d;
    logic [3:0]    count_q,     count_d;
    logic          wr_req_q,    wr_req_d;
    word_t         head_q,      head_d;
    word_t         mem [FIFO_DEPTH];

    logic        accept;
    logic        out_of_range;
    logic        pop;
    logic        push;
    logic        room;
    word_t       push_w;
    logic [18:0] acc_addr;
    logic [3:0]  remain;

    assign accept       = pt_wr & ptflag_q;
    assign out_of_range = (pt_x > 10'd639) || (pt_y > 9'd479);
    assign acc_addr     = 19'(pt_y) * 19'(H_WORDS) + 19'(pt_x[9:1]);
    assign pop          = wr_req_q & wr_ack;
    assign room         = (count_q != DEPTH_C) | pop;

    // Pixel pairing: at most one word leaves the packer per cycle, and an
    // accept-generated push always wins over a flush of the lone pending pixel.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_half_d = pend_half_q;
        pend_data_d = pend_data_q;
        idle_d      = idle_q;
        flush_req_d = flush_req_q | frame_flag;
        oob_d       = oob_q & ~frame_flag;
        push        = 1'b0;
        push_w      = '0;

        if (accept) begin
            idle_d = '0;
            if (out_of_range) begin
                oob_d = 1'b1;
            end else if (!pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = acc_addr;
                pend_half_d = pt_x[0];
                pend_data_d = pt_pixel_write;
            end else if (pend_addr_q == acc_addr) begin
                if (pend_half_q != pt_x[0]) begin
                    push        = 1'b1;
                    push_w.addr = acc_addr;
                    push_w.data = pt_x[0] ? {pt_pixel_write, pend_data_q}
                                          : {pend_data_q, pt_pixel_write};
                    push_w.mask = 2'b11;
                    pend_vld_d  = 1'b0;
                end else begin
                    pend_data_d = pt_pixel_write;
                end
            end else begin
                push        = 1'b1;
                push_w      = lone_word(pend_addr_q, pend_half_q, pend_data_q);
                pend_addr_d = acc_addr;
                pend_half_d = pt_x[0];
                pend_data_d = pt_pixel_write;
            end
        end else if (pend_vld_q) begin
            if (idle_q != IDLE_LAST_C) begin
                idle_d = idle_q + IW'(1);
            end
            if ((flush_req_q || idle_q == IDLE_LAST_C) && room) begin
                push        = 1'b1;
                push_w      = lone_word(pend_addr_q, pend_half_q, pend_data_q);
                pend_vld_d  = 1'b0;
                idle_d      = '0;
                flush_req_d = frame_flag;
            end
        end else begin
            idle_d      = '0;
            flush_req_d = frame_flag;
        end
    end

    // Word FIFO: the head is re-registered every cycle so the memory port sees
    // registered address/data/mask straight from flops.
    always_comb begin
        remain   = count_q - {3'b000, pop};
        count_d  = remain + {3'b000, push};
        rd_d     = pop  ? rd_q + PW'(1) : rd_q;
        wr_d     = push ? wr_q + PW'(1) : wr_q;
        ptflag_d = (count_d <= HIWAT_C);
        wr_req_d = (count_d != 4'd0);
        if (count_d == 4'd0) begin
            head_d = '0;
        end else if (remain == 4'd0) begin
            head_d = push_w;
        end else begin
            head_d = mem[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= push_w;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_half_q <= 1'b0;
            pend_data_q <= '0;
            idle_q      <= '0;
            flush_req_q <= 1'b0;
            oob_q       <= 1'b0;
            ptflag_q    <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            wr_req_q    <= 1'b0;
            head_q      <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_half_q <= pend_half_d;
            pend_data_q <= pend_data_d;
            idle_q      <= idle_d;
            flush_req_q <= flush_req_d;
            oob_q       <= oob_d;
            ptflag_q    <= ptflag_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            wr_req_q    <= wr_req_d;
            head_q      <= head_d;
        end
    end

    assign ptflag     = ptflag_q;
    assign wr_req     = wr_req_q;
    assign wr_addr    = head_q.addr;
    assign wr_data    = head_q.data;
    assign wr_mask    = head_q.mask;
    assign fifo_count = count_q;
    assign oob_err    = oob_q;

endmodule

// File: doc/pt_write_packer.md
Name: pt_write_packer

Overview:
- Sits directly downstream of the projective transform stage, between its pixel-write output and the frame-buffer memory arbiter.
- Accepts transformed pixels with their (x,y) destination and computes the 36-bit ZBT word address.
- Pairs horizontally adjacent 18-bit pixels into one 36-bit word with a half-word mask, then queues the words in a small FIFO for the memory port.
- Its flow-control output (ptflag) is the back-pressure to the projective transform stage.

Parameters:
FIFO_DEPTH, 8, word-FIFO entries (power of two, >=4)
H_WORDS, 320, 36-bit words per display line (640 px / 2)
IDLE_FLUSH, 16, cycles without an accepted write before a lone pending pixel is pushed

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pt_pixel_write  in  18  pixel data from projective transform
pt_x  in  10  destination x, valid 0..639
pt_y  in  9  destination y, valid 0..479
pt_wr  in  1  write request, qualified by ptflag
ptflag  out  1  ok-to-send; a write is accepted in any cycle with pt_wr=1 and ptflag=1
frame_flag  in  1  new-frame pulse; forces flush of pending pixel, clears oob_err
wr_addr  out  19  word address = pt_y*H_WORDS + pt_x[9:1]
wr_data  out  36  [35:18] odd-x pixel, [17:0] even-x pixel
wr_mask  out  2  bit1 = upper half valid, bit0 = lower half valid
wr_req  out  1  FIFO head valid
wr_ack  in  1  memory arbiter consumed head this cycle
fifo_count  out  4  entries in FIFO (0..FIFO_DEPTH)
oob_err  out  1  sticky: an out-of-range coordinate was dropped

Behaviour:
- Reset (async assert, sync release): FIFO empty, pending empty, flush_req=0, idle counter=0.
- Output reset values: ptflag=0, wr_req=0, wr_addr=0, wr_data=0, wr_mask=0, fifo_count=0, oob_err=0.
- ptflag is registered. It is 1 when the post-update fifo_count <= FIFO_DEPTH-2 (one slot of slack), otherwise 0. It goes high the first clk after reset release.
- Accept path (pt_wr & ptflag). Compute addr A = pt_y*H_WORDS + pt_x[9:1] and half h = pt_x[0]. Then:
  - pt_x>639 or pt_y>479: pixel dropped, oob_err<=1, pending untouched.
  - Pending empty: pixel becomes pending {A, h, data}.
  - Pending valid, same A, opposite half: merged word {A, data pair, mask 2'b11} pushed; pending cleared.
  - Pending valid, same A, same half: pending data overwritten (last write wins); no push.
  - Pending valid, different A: pending pushed alone (mask 2'b10 if h_pend=1, else 2'b01); new pixel becomes pending.
  - In all cases the idle counter resets to 0.
- Idle flush: pending valid and no accept for IDLE_FLUSH consecutive cycles -> pending pushed alone, pending cleared.
- frame_flag: sets sticky flush_req and clears oob_err in the same cycle; if a drop occurs that same cycle, oob_err ends 1. flush_req pushes pending alone on the first cycle with no other push, then clears. If pending is empty, flush_req clears immediately.
- At most one push per cycle. Priority: accept-generated push > idle/frame flush (a flush waits a cycle).
- FIFO: wr_req = (count != 0); wr_addr/wr_data/wr_mask show the head, registered, stable while wr_req=1 and wr_ack=0. Pop on wr_req & wr_ack. Simultaneous push and pop: count unchanged, ordering preserved. wr_ack with FIFO empty is ignored.
- Address arithmetic: 19-bit unsigned; max 479*320+319 = 153599. Multiply by H_WORDS may be shift-add (y<<8 + y<<6).
- Output data ordering is the same as accept order; memory sees each word exactly once.

Test Plan:
- Pair merge: after reset, write (x=10,y=2,0x00AAA) then (x=11,y=2,0x15555) -> one entry: wr_addr=645, wr_data={0x15555,0x00AAA}, wr_mask=2'b11.
- Split: write (x=3,y=0,D1) then (x=8,y=0,D2), hold wr_ack=1 -> word addr=1 mask=2'b10 data[35:18]=D1; after IDLE_FLUSH idle cycles, word addr=4 mask=2'b01 data[17:0]=D2.
- Back-pressure: wr_ack=0, stream 20 consecutive even/odd pairs -> ptflag falls when fifo_count reaches 7; no write is lost; releasing wr_ack drains in order with addresses incrementing by 1.
- Frame flush: pending (x=639,y=479,D) and frame_flag pulse with oob_err=1 -> word addr=153599 mask=2'b10 pushed next cycle; oob_err=0.
- Out-of-range: write x=700,y=10 -> nothing pushed, oob_err=1, pending unchanged.
- Reset mid-operation: assert reset_n=0 with 5 entries queued and a pending pixel -> outputs zero immediately, fifo_count=0. After release, no stale word ever appears on wr_req.
